// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: size codes, FSM states,
// byte-lane masks and small helpers for alignment and store lane steering.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_X = 2'd3;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Half must be even, word must be 4-aligned, size code 3 is never legal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lane[0];
      SIZE_W:  return (lane != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Byte-lane write strobes for an aligned store.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_B:  return LANE_B << lane;
      SIZE_H:  return LANE_H << lane;
      default: return LANE_W;
    endcase
  endfunction

  // Replicate right-justified store data so every candidate lane carries it;
  // the strobes then pick which lanes the RAM actually updates.
  function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_B:  return {4{wdata[7:0]}};
      SIZE_H:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load extraction: picks the addressed byte/half/word out of
// the RAM read word and zero- or sign-extends it to 32 bits.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign byte_lane[gi] = rdata[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign half_lane[gi] = rdata[16*gi +: 16];
  end

  // Select the addressed field and extend it according to signedness.
  always_comb begin
    sel_byte = byte_lane[lane];
    sel_half = half_lane[lane[1]];
    data     = rdata;
    case (size)
      SIZE_B:  data = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
      SIZE_H:  data = {{16{~is_unsigned & sel_half[15]}}, sel_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit in front of a 32-bit byte-laned RAM.
// Aligned requests take IDLE -> ACCESS -> RESP; misaligned or illegal-size
// requests skip the RAM entirely and answer with an error one cycle later.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              mem_chip_select,
  output logic              mem_output_enable,
  output logic [3:0]        mem_write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_error_q, resp_error_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [1:0]          lane_q, lane_d;
  logic [ADDR_W-3:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   load_data;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

  load_align u_load_align (
    .rdata       (mem_read_data),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .data        (load_data)
  );

  // Next-state and next-output logic; the response is formed on the way into RESP.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_error_d = 1'b0;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    lane_d       = lane_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          lane_d      = req_addr[1:0];
          waddr_d     = req_addr[ADDR_W-1:2];
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = write_q ? '0 : load_data;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // FSM and registered outputs; reset returns to an idle, ready, silent unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      write_q      <= 1'b0;
      size_q       <= SIZE_B;
      unsigned_q   <= 1'b0;
      lane_q       <= 2'b00;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      lane_q       <= lane_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  // RAM strobes are decoded from the ACCESS state only, so reset kills them at once.
  always_comb begin
    mem_chip_select   = 1'b0;
    mem_output_enable = 1'b0;
    mem_write_enable  = 4'b0000;
    mem_addr          = '0;
    mem_write_data    = '0;
    if (state_q == ACCESS) begin
      mem_chip_select = 1'b1;
      mem_addr        = {waddr_q, 2'b00};
      if (write_q) begin
        mem_write_enable = lane_mask(size_q, lane_q);
        mem_write_data   = store_replicate(size_q, wdata_q);
      end else begin
        mem_output_enable = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural byte-laned RAM.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_chip_select, mem_output_enable;
  logic [3:0]  mem_write_enable;
  logic [11:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;

  logic [31:0] ram [1024];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_chip_select(mem_chip_select), .mem_output_enable(mem_output_enable),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Behavioural RAM: asynchronous read, byte-laned synchronous write.
  assign mem_read_data = (mem_chip_select && mem_output_enable) ? ram[mem_addr[11:2]] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (mem_chip_select) begin
      for (int b = 0; b < 4; b++)
        if (mem_write_enable[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  we;
    logic [31:0] mwdata;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                              input logic [11:0] addr, input logic [31:0] wdata, input logic err,
                              input logic [31:0] rdata, input logic [3:0] we, input logic [31:0] mwdata);
    vec_t v;
    v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.we = we; v.mwdata = mwdata;
    return v;
  endfunction

  // Issue one request, watch the RAM port, and check the response.
  task automatic run_vec(input int idx, input vec_t v);
    bit          done = 0;
    bit          saw_cs = 0;
    int          cyc = 0;
    int          lat = 0;
    logic [3:0]  we_s = 4'h0;
    logic [31:0] wd_s = 32'h0;
    logic [11:0] ad_s = 12'h0;
    logic        oe_s = 1'b0;
    logic [31:0] rd_s = 32'h0;
    logic        er_s = 1'b0;
    @(negedge clk);
    chk("ready_before", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!done && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (mem_chip_select) begin
        saw_cs = 1; we_s = mem_write_enable; wd_s = mem_write_data;
        ad_s = mem_addr; oe_s = mem_output_enable;
      end
      if (resp_valid) begin
        done = 1; lat = cyc; rd_s = resp_rdata; er_s = resp_error;
      end
    end
    chk("resp_seen", {31'h0, done}, 32'h1);
    chk("latency", lat, v.err ? 1 : 2);
    chk("resp_error", {31'h0, er_s}, {31'h0, v.err});
    chk("resp_rdata", rd_s, v.rdata);
    chk("cs_pulse", {31'h0, saw_cs}, {31'h0, ~v.err});
    if (!v.err) begin
      chk("mem_addr", {20'h0, ad_s}, {20'h0, v.addr[11:2], 2'b00});
      chk("mem_we", {28'h0, we_s}, {28'h0, v.we});
      chk("mem_oe", {31'h0, oe_s}, {31'h0, ~v.wr});
      if (v.wr) chk("mem_wdata", wd_s, v.mwdata);
    end
    @(negedge clk);
    chk("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
    chk("ready_after", {31'h0, req_ready}, 32'h1);
    $display("[TB] vec %0d wr=%0d size=%0d addr=0x%03h -> rdata=0x%08h err=%0d lat=%0d",
             idx, v.wr, v.size, v.addr, rd_s, er_s, lat);
  endtask

  vec_t vecs [15];

  initial begin
    logic [31:0] resp_q [$];
    int          acc_cyc [3];
    int          n_acc;
    bit          sw;
    bit          bad_resp;
    logic [1:0]  b2b_size [3];
    logic [11:0] b2b_addr [3];
    logic        b2b_uns  [3];

    //                wr    size    uns   addr    wdata          err   rdata          we       mwdata
    vecs[0]  = mk(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 32'h00000000, 4'b1111, 32'hDEADBEEF);
    vecs[1]  = mk(1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        1'b0, 32'hDEADBEEF, 4'b0000, 32'h0);
    vecs[2]  = mk(1'b1, 2'd0, 1'b0, 12'h013, 32'h00000080, 1'b0, 32'h00000000, 4'b1000, 32'h80808080);
    vecs[3]  = mk(1'b0, 2'd0, 1'b0, 12'h013, 32'h0,        1'b0, 32'hFFFFFF80, 4'b0000, 32'h0);
    vecs[4]  = mk(1'b0, 2'd0, 1'b1, 12'h013, 32'h0,        1'b0, 32'h00000080, 4'b0000, 32'h0);
    vecs[5]  = mk(1'b1, 2'd1, 1'b0, 12'h022, 32'h00001234, 1'b0, 32'h00000000, 4'b1100, 32'h12341234);
    vecs[6]  = mk(1'b0, 2'd1, 1'b1, 12'h022, 32'h0,        1'b0, 32'h00001234, 4'b0000, 32'h0);
    vecs[7]  = mk(1'b0, 2'd2, 1'b0, 12'h005, 32'h0,        1'b1, 32'h00000000, 4'b0000, 32'h0);
    vecs[8]  = mk(1'b1, 2'd1, 1'b0, 12'h001, 32'h0000ABCD, 1'b1, 32'h00000000, 4'b0000, 32'h0);
    vecs[9]  = mk(1'b0, 2'd3, 1'b0, 12'h000, 32'h0,        1'b1, 32'h00000000, 4'b0000, 32'h0);
    vecs[10] = mk(1'b0, 2'd0, 1'b0, 12'h010, 32'h0,        1'b0, 32'hFFFFFFEF, 4'b0000, 32'h0);
    vecs[11] = mk(1'b0, 2'd1, 1'b0, 12'h012, 32'h0,        1'b0, 32'hFFFF80AD, 4'b0000, 32'h0);
    vecs[12] = mk(1'b0, 2'd1, 1'b1, 12'h010, 32'h0,        1'b0, 32'h0000BEEF, 4'b0000, 32'h0);
    vecs[13] = mk(1'b1, 2'd0, 1'b0, 12'h021, 32'h123456A5, 1'b0, 32'h00000000, 4'b0010, 32'hA5A5A5A5);
    vecs[14] = mk(1'b0, 2'd2, 1'b0, 12'h020, 32'h0,        1'b0, 32'h1234A500, 4'b0000, 32'h0);

    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_error", {31'h0, resp_error}, 32'h0);
    chk("rst_mem", {mem_chip_select, mem_output_enable, mem_write_enable, 14'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Back-to-back loads with req_valid held high throughout.
    b2b_size = '{2'd2, 2'd2, 2'd0};
    b2b_addr = '{12'h010, 12'h020, 12'h013};
    b2b_uns  = '{1'b0, 1'b0, 1'b1};
    n_acc = 0; sw = 0; bad_resp = 0;
    @(negedge clk);
    req_valid = 1; req_write = 0;
    req_size = b2b_size[0]; req_addr = b2b_addr[0]; req_unsigned = b2b_uns[0];
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (sw) begin
        sw = 0;
        if (n_acc < 3) begin
          req_size = b2b_size[n_acc]; req_addr = b2b_addr[n_acc]; req_unsigned = b2b_uns[n_acc];
        end else begin
          req_valid = 0;
        end
      end
      if (resp_valid) begin
        resp_q.push_back(resp_rdata);
        if (resp_error) bad_resp = 1;
      end
      if (req_ready && req_valid && n_acc < 3) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        sw = 1;
      end
    end
    chk("b2b_accepts", n_acc, 3);
    chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 3);
    chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 3);
    chk("b2b_resp_count", resp_q.size(), 3);
    chk("b2b_no_error", {31'h0, bad_resp}, 32'h0);
    if (resp_q.size() == 3) begin
      chk("b2b_resp0", resp_q[0], 32'h80ADBEEF);
      chk("b2b_resp1", resp_q[1], 32'h1234A500);
      chk("b2b_resp2", resp_q[2], 32'h00000080);
    end
    $display("[TB] back-to-back accepts at cycles %0d,%0d,%0d responses=%0d",
             acc_cyc[0], acc_cyc[1], acc_cyc[2], resp_q.size());

    // Reset in the middle of a word store: strobes drop at once, nothing is written.
    @(negedge clk);
    req_valid = 1; req_write = 1; req_size = 2'd2; req_unsigned = 0;
    req_addr = 12'h010; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 0;
    chk("abort_in_access", {31'h0, mem_chip_select}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("abort_cs", {31'h0, mem_chip_select}, 32'h0);
    chk("abort_we", {28'h0, mem_write_enable}, 32'h0);
    chk("abort_oe_addr", {20'h0, mem_output_enable, 11'h0} | {20'h0, mem_addr}, 32'h0);
    chk("abort_wdata", mem_write_data, 32'h0);
    begin
      bit saw_resp = 0;
      repeat (2) begin
        @(negedge clk);
        if (resp_valid) saw_resp = 1;
      end
      rst = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (resp_valid) saw_resp = 1;
      end
      chk("abort_no_resp", {31'h0, saw_resp}, 32'h0);
    end
    $display("[TB] reset during ACCESS of word store to 0x010");
    run_vec(100, mk(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1'b0, 32'h80ADBEEF, 4'b0000, 32'h0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
